// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Multiplies are shift-add and divides are restoring; each takes WIDTH steps, then one FIN cycle to write HI/LO.
module mips_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t state, state_next;

  // acc holds the product while multiplying, and {remainder, quotient} while dividing
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  logic               neg;
  logic               rneg;
  logic               is_div;
  logic               dz;

  logic               start_mul;
  logic               start_div;
  logic               is_signed;
  logic               last;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  assign start_mul = (state == IDLE) && start && (op == OP_MULT || op == OP_MULTU);
  assign start_div = (state == IDLE) && start && (op == OP_DIV || op == OP_DIVU);
  assign is_signed = ~op[0];
  assign last      = (count == CW'(WIDTH - 1));

  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
  assign mul_next  = {mul_sum, acc[WIDTH-1:1]};

  // A borrow out of the trial subtraction means the divisor did not fit, so the shifted remainder is kept
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mcand};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start_mul)      state_next = MUL;
        else if (start_div) state_next = (b == '0) ? FIN : DIV;
      end
      MUL: begin
        busy = 1'b1;
        if (last) state_next = FIN;
      end
      DIV: begin
        busy = 1'b1;
        if (last) state_next = FIN;
      end
      FIN: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      count       <= '0;
      neg         <= 1'b0;
      rneg        <= 1'b0;
      is_div      <= 1'b0;
      dz          <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_mul) begin
            mcand       <= magnitude(a, is_signed);
            mplier      <= magnitude(b, is_signed);
            neg         <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc         <= '0;
            count       <= '0;
            is_div      <= 1'b0;
            dz          <= 1'b0;
            div_by_zero <= 1'b0;
          end else if (start_div) begin
            mcand       <= magnitude(b, is_signed);
            acc         <= {{WIDTH{1'b0}}, magnitude(a, is_signed)};
            neg         <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg        <= is_signed & a[WIDTH-1];
            count       <= '0;
            is_div      <= 1'b1;
            dz          <= (b == '0);
            div_by_zero <= 1'b0;
          end else if (start && op == OP_MTHI) begin
            hi          <= a;
            div_by_zero <= 1'b0;
          end else if (start && op == OP_MTLO) begin
            lo          <= a;
            div_by_zero <= 1'b0;
          end
        end
        MUL: begin
          acc    <= mul_next;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
        end
        DIV: begin
          acc   <= div_next;
          count <= count + 1'b1;
        end
        FIN: begin
          done <= 1'b1;
          if (dz) begin
            div_by_zero <= 1'b1;
          end else if (is_div) begin
            lo <= neg  ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
            hi <= rneg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
          end else begin
            {hi, lo} <= neg ? -acc : acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv: directed cases plus random ops against a plain-arithmetic HI/LO model.
module tb_mips_muldiv;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_dz = 1'b0;

  mips_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // HI/LO behaviour from plain 64-bit arithmetic on the operands
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       inout logic [31:0] h, inout logic [31:0] l, inout logic dz);
    longint          p;
    longint unsigned pu;
    int              sx, sy;
    sx = x;
    sy = y;
    case (o)
      3'd0: begin p = longint'(sx) * longint'(sy); {h, l} = p; dz = 1'b0; end
      3'd1: begin pu = {32'b0, x} * {32'b0, y}; {h, l} = pu; dz = 1'b0; end
      3'd2: begin
        if (y == 0) dz = 1'b1;
        else begin
          dz = 1'b0;
          if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin l = x; h = 0; end
          else begin l = sx / sy; h = sx % sy; end
        end
      end
      3'd3: begin
        if (y == 0) dz = 1'b1;
        else begin dz = 1'b0; l = x / y; h = x % y; end
      end
      3'd4: begin h = x; dz = 1'b0; end
      3'd5: begin l = x; dz = 1'b0; end
      default: ;
    endcase
  endtask

  // Present one request, hold it across one rising edge, then scramble the inputs
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic waitDone(input string tag, inout int lat);
    while (done !== 1'b1 && lat < 40) begin
      checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
      checkOutput({tag, "_hold_hi"}, hi, m_hi);
      checkOutput({tag, "_hold_lo"}, lo, m_lo);
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finishCheck(input string tag, input int lat, input int exp_lat,
                             input logic [31:0] e_hi, input logic [31:0] e_lo, input logic e_dz);
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_busy_end"}, 32'(busy), 32'd0);
    checkOutput({tag, "_hi"}, hi, e_hi);
    checkOutput({tag, "_lo"}, lo, e_lo);
    checkOutput({tag, "_dz"}, 32'(div_by_zero), 32'(e_dz));
    m_hi = e_hi;
    m_lo = e_lo;
    m_dz = e_dz;
  endtask

  task automatic doOp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
    logic [31:0] e_hi, e_lo;
    logic        e_dz;
    int          lat;
    e_hi = m_hi;
    e_lo = m_lo;
    e_dz = m_dz;
    model(o, x, y, e_hi, e_lo, e_dz);
    applyStimulus(o, x, y);
    if (o <= 3'd3) begin
      lat = 0;
      checkOutput({tag, "_done_low"}, 32'(done), 32'd0);
      waitDone(tag, lat);
      finishCheck(tag, lat, (o[1] && y == 0) ? 1 : 33, e_hi, e_lo, e_dz);
    end else begin
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
      checkOutput({tag, "_hi"}, hi, e_hi);
      checkOutput({tag, "_lo"}, lo, e_lo);
      checkOutput({tag, "_dz"}, 32'(div_by_zero), 32'(e_dz));
      m_hi = e_hi;
      m_lo = e_lo;
      m_dz = e_dz;
    end
  endtask

  initial begin
    logic [31:0] e_hi, e_lo;
    logic        e_dz;
    int          lat;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    rst   = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_dz", 32'(div_by_zero), 32'd0);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    doOp(3'd0, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7");
    doOp(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    doOp(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_m1xm1");
    doOp(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
    doOp(3'd3, 32'd7, 32'd2, "divu_7by2");
    doOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    doOp(3'd3, 32'd100, 32'd0, "divu_by_zero");
    doOp(3'd0, 32'd5, 32'd6, "mult_clears_dz");
    doOp(3'd4, 32'h1234_5678, 32'd0, "mthi");
    doOp(3'd5, 32'h9ABC_DEF0, 32'd0, "mtlo");
    doOp(3'd6, 32'hDEAD_BEEF, 32'd1, "op_ignored");

    // A MULT request arriving mid-divide must be dropped
    e_hi = m_hi;
    e_lo = m_lo;
    e_dz = m_dz;
    model(3'd2, 32'hFFFF_FC18, 32'd7, e_hi, e_lo, e_dz);
    applyStimulus(3'd2, 32'hFFFF_FC18, 32'd7);
    lat = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      lat++;
    end
    @(negedge clk);
    start = 1'b1;
    op    = 3'd0;
    a     = 32'd3;
    b     = 32'd3;
    @(posedge clk);
    #1;
    lat++;
    start = 1'b0;
    waitDone("busy_start", lat);
    finishCheck("busy_start", lat, 33, e_hi, e_lo, e_dz);

    // Reset in the middle of a divide discards it with no done pulse
    applyStimulus(3'd2, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    checkOutput("midreset_hi", hi, 32'd0);
    checkOutput("midreset_lo", lo, 32'd0);
    m_hi = '0;
    m_lo = '0;
    m_dz = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      checkOutput("midreset_no_done", 32'(done), 32'd0);
    end

    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
      if ($urandom_range(0, 3) == 0) ra = -ra;
      $display("[TB] random op %0d: op=%0d a=%h b=%h", i, ro, ra, rb);
      doOp(ro, ra, rb, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_muldiv.md
# mips_muldiv

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the MIPS core family. It adds MULT, MULTU, DIV, DIVU, MTHI and MTLO, which the single-cycle datapath lacks. The unit sits beside the ALU in the execute stage. The core holds PC while `busy` is high, and MFHI/MFLO read `hi`/`lo` combinationally.

## Interface
Parameters:
- WIDTH, 32, operand/HI/LO width; even, ≥4.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (sampled on rising edge of clk, asserted when 0).
- start  in  1  request; sampled only in IDLE.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored.
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source).
- b  in  WIDTH  rt operand (divisor / multiplier).
- busy  out  1  operation in progress; start ignored while high.
- done  out  1  one-cycle pulse: hi/lo hold the new result.
- div_by_zero  out  1  set by DIV/DIVU with b==0; cleared by the next accepted start.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- FSM states: IDLE, MUL, DIV, FIN.
- IDLE with start=1 and op=MULT/MULTU:
  - latch |a|, |b| (unsigned ops: raw values) and neg = a[W-1]^b[W-1] (signed only).
  - clear the 2·WIDTH accumulator and iteration counter; go to MUL.
- MUL: one shift-add step per cycle (multiplier LSB first); WIDTH steps, then FIN.
- IDLE with start=1 and op=DIV/DIVU, b≠0:
  - latch magnitudes, qneg = a[W-1]^b[W-1], rneg = a[W-1] (signed only); go to DIV.
- DIV: one restoring shift-subtract step per cycle; WIDTH steps, then FIN.
- FIN:
  - MUL result: {hi,lo} ← neg ? −product : product (2·WIDTH two's complement).
  - DIV result: lo ← qneg ? −quotient : quotient; hi ← rneg ? −remainder : remainder.
  - return to IDLE.
- DIV/DIVU with b==0:
  - go straight to FIN without iterating; hi/lo unchanged.
  - div_by_zero ← 1.
- Signed overflow (MIN / −1): lo = MIN (wraps), hi = 0. No flag is raised.
- MTHI/MTLO: hi (or lo) ← a on the accepting edge. busy and done stay 0. FSM stays in IDLE.
- op 110/111 with start: no effect, and div_by_zero is not cleared.
- Counter width is clog2(WIDTH)+1. Iteration count is exactly WIDTH for every operand value; there is no early termination.

## Timing
- Reset (rst=0 at an edge):
  - FSM → IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0.
  - An in-flight operation is aborted with no partial HI/LO write.
- Start accepted at edge k (mult/div, b≠0):
  - busy=1 from after edge k through FIN.
  - hi/lo and done=1 visible after edge k+WIDTH+1; busy=0 in that same cycle.
  - Latency is WIDTH+1 cycles.
- Divide by zero:
  - done=1 and div_by_zero=1 after edge k+1.
  - busy=1 for exactly one cycle.
- done is high for exactly one cycle.
- A new start may be accepted in the done cycle; back-to-back throughput is one op per WIDTH+1 cycles.
- a, b and op need only be valid at the accepting edge. Later changes to them have no effect.
- hi/lo change only at FIN, MTHI/MTLO or reset. They are stable during busy, which lets an MFHI during busy return the old value.

## Test plan
All values assume WIDTH=32.
- MULT a=0xFFFFFFFD (−3), b=7 → done 33 cycles after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high 33 cycles.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. MULT on the same operands → hi=0, lo=1.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. DIVU a=100, b=0 → done 1 cycle later, div_by_zero=1, hi/lo unchanged. The next MULT clears div_by_zero.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on the next cycle → hi/lo updated on each edge; busy and done never assert.
- Start DIV. Pulse start with MULT at cycle 5 → ignored, and the DIV result is correct. Drive rst=0 at cycle 10 of a second DIV → busy=0, hi=lo=0 after that edge, and no done pulse.
